// File: rtl/serial_twos_complement.sv
// Bit-serial negate / absolute value, LSB first, one operand bit per clock.
// Define SERIAL_TWOS_COMPLEMENT_SAT_EN to saturate the overflow case to the most-positive value.
module serial_twos_complement #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MAX_VAL = ~MIN_VAL;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] x;
    logic [WIDTH-2:0] acc;
    logic [CW-1:0]    cnt;
    logic             inv;
    logic             carry;

    logic             b;
    logic             rbit;
    logic [WIDTH-1:0] res;

    // One serial step: conditional inversion plus ripple of the +1 carry.
    always_comb begin
        b    = x[0] ^ inv;
        rbit = b ^ carry;
        res  = {rbit, acc};
    end

    // Combinational so a capture is possible on the very first edge after reset release.
    assign in_ready = (state == IDLE) && rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            x         <= '0;
            acc       <= '0;
            cnt       <= '0;
            inv       <= 1'b0;
            carry     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x       <= in_data;
                        acc     <= '0;
                        cnt     <= '0;
                        inv     <= !mode || in_data[WIDTH-1];
                        carry   <= !mode || in_data[WIDTH-1];
                        out_ovf <= (in_data == MIN_VAL);
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    x     <= x >> 1;
                    carry <= b & carry;
                    acc   <= res[WIDTH-1:1];
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
`ifdef SERIAL_TWOS_COMPLEMENT_SAT_EN
                        out_data  <= out_ovf ? MAX_VAL : res;
`else
                        out_data  <= res;
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_twos_complement.sv
// Directed self-checking bench for serial_twos_complement at WIDTH=5.
module tb_serial_twos_complement;

    localparam int unsigned W = 5;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic         mode;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_ovf;
    logic         busy;

    int checks = 0;
    int failures = 0;

    serial_twos_complement #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mode     (mode),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_ovf  (out_ovf),
        .busy     (busy)
    );

    always #5 clk = ~clk;

`ifdef SERIAL_TWOS_COMPLEMENT_SAT_EN
    localparam logic [W-1:0] MIN_RES = 5'b01111;
`else
    localparam logic [W-1:0] MIN_RES = 5'b10000;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operand, verify latency and result, optionally stall the output.
    task automatic run_op(input string tag, input logic m, input logic [W-1:0] d,
                          input logic [W-1:0] exp_d, input logic exp_ovf, input int stall);
        int waited;
        int lat;
        waited = 0;
        while (!in_ready && waited < 20) begin
            tick();
            waited++;
        end
        check({tag, "_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        mode     = m;
        in_data  = d;
        tick();
        // Post-capture input changes must not matter.
        mode    = ~m;
        in_data = ~d;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(W + 1));
        check({tag, "_data"}, 32'(out_data), 32'(exp_d));
        check({tag, "_ovf"}, 32'(out_ovf), 32'(exp_ovf));
        for (int s = 0; s < stall; s++) begin
            in_valid = s[0];
            in_data  = 5'(s * 7);
            tick();
            check({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_stall_data"}, 32'(out_data), 32'(exp_d));
            check({tag, "_stall_ovf"}, 32'(out_ovf), 32'(exp_ovf));
            check({tag, "_stall_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_released"}, 32'(out_valid), 32'd0);
        check({tag, "_idle"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [W-1:0] ops  [3];
        logic [W-1:0] exps [3];
        int cap_edge [3];
        int n_cap;
        int n_out;
        int edge_no;
        int seen;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        mode      = 1'b0;
        in_data   = '0;
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_ovf", 32'(out_ovf), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;

        run_op("neg7", 1'b0, 5'b00111, 5'b11001, 1'b0, 0);
        run_op("neg0", 1'b0, 5'b00000, 5'b00000, 1'b0, 0);
        run_op("negmin", 1'b0, 5'b10000, MIN_RES, 1'b1, 0);
        run_op("absmin", 1'b1, 5'b10000, MIN_RES, 1'b1, 0);
        run_op("absm1", 1'b1, 5'b11111, 5'b00001, 1'b0, 0);
        run_op("abs7", 1'b1, 5'b00111, 5'b00111, 1'b0, 0);
        run_op("abs15", 1'b1, 5'b01111, 5'b01111, 1'b0, 0);
        run_op("stall", 1'b0, 5'b00011, 5'b11101, 1'b0, 3);

        // Reset while bit 2 is being shifted.
        in_valid = 1'b1;
        mode     = 1'b0;
        in_data  = 5'b01010;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_data", 32'(out_data), 32'd0);
        check("midrst_ovf", 32'(out_ovf), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("midrst_no_result", 32'(seen), 32'd0);
        run_op("after_rst", 1'b0, 5'b00001, 5'b11111, 1'b0, 0);

        // Back-to-back with in_valid and out_ready held high.
        ops[0] = 5'b00010; exps[0] = 5'b11110;
        ops[1] = 5'b00101; exps[1] = 5'b11011;
        ops[2] = 5'b01111; exps[2] = 5'b10001;
        n_cap = 0;
        n_out = 0;
        edge_no = 0;
        mode = 1'b0;
        out_ready = 1'b1;
        while (n_out < 3 && edge_no < 60) begin
            if (in_ready && n_cap < 3) begin
                in_valid = 1'b1;
                in_data  = ops[n_cap];
                cap_edge[n_cap] = edge_no + 1;
                n_cap++;
            end else if (n_cap >= 3) begin
                in_valid = 1'b0;
            end
            tick();
            edge_no++;
            if (out_valid) begin
                check("b2b_data", 32'(out_data), 32'(exps[n_out]));
                n_out++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b_results", 32'(n_out), 32'd3);
        check("b2b_gap01", 32'(cap_edge[1] - cap_edge[0]), 32'(W + 2));
        check("b2b_gap12", 32'(cap_edge[2] - cap_edge[1]), 32'(W + 2));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
